// File: rtl/main_reduced_dac.sv
// Single-channel amplifier-to-DAC output path: frame sequencer, sample conditioning,
// serial DAC shifter and threshold/window logic. Define MAIN_REDUCED_HPF_EN to build the HPF.
module main_reduced_dac (
  input  logic        dataclk,
  input  logic        reset,
  input  logic [15:0] ampl_to_DAC,
  input  logic        SPI_start,
  input  logic [15:0] DAC_sequencer_1,
  input  logic        DAC_sequencer_en_1,
  input  logic        DAC_en,
  input  logic [2:0]  DAC_gain,
  input  logic [6:0]  DAC_noise_suppress,
  input  logic [15:0] HPF_coefficient,
  input  logic        HPF_en,
  input  logic        DAC_reref_mode,
  input  logic        DAC_1_input_is_ref,
  input  logic [15:0] DAC_reref_register,
  input  logic [15:0] DAC_thrsh_1,
  input  logic        DAC_thrsh_pol_1,
  input  logic        DAC_fsm_mode,
  input  logic [7:0]  DAC_edge_type,
  input  logic [15:0] DAC_start_win_1,
  input  logic [15:0] DAC_stop_win_1,
  input  logic [15:0] DAC_stop_max,
  output logic        DAC_thresh_out,
  output logic        fsm_window_state,
  output logic [15:0] DAC_output_register_1,
  output logic        DAC_SYNC,
  output logic        DAC_SCLK,
  output logic        DAC_DIN,
  output logic [31:0] main_state,
  output logic [5:0]  channel,
  output logic        sample_CLK_out
);

  typedef enum logic {WIN_IDLE, WIN_COUNT} win_state_t;

  // ---------------- frame sequencer ----------------
  logic [4:0]  st_q, st_nxt;
  logic [5:0]  ch_q, ch_nxt;
  logic        advance;
  logic        spi_active;
  logic [3:0]  bit_idx;
  logic [15:0] spi_src, spi_word_q;
  logic [15:0] out_q;

  // A frame in progress always completes; only the 0/0 position waits for SPI_start.
  always_comb begin
    advance = SPI_start || (st_q != '0) || (ch_q != '0);
    st_nxt  = st_q;
    ch_nxt  = ch_q;
    if (advance) begin
      st_nxt = st_q + 5'd1;
      if (st_q == 5'd31) ch_nxt = (ch_q == 6'd34) ? '0 : ch_q + 6'd1;
    end
    spi_active = advance && (ch_nxt == 6'd34);
    bit_idx    = 4'd15 - st_nxt[4:1];
    spi_src    = (st_nxt == '0) ? out_q : spi_word_q;
  end

  // Bus outputs are registered from the next counter value so they line up with main_state.
  always_ff @(posedge dataclk) begin
    if (!reset) begin
      st_q           <= '0;
      ch_q           <= '0;
      sample_CLK_out <= 1'b0;
      DAC_SYNC       <= 1'b1;
      DAC_SCLK       <= 1'b0;
      DAC_DIN        <= 1'b0;
      spi_word_q     <= '0;
    end else begin
      st_q           <= st_nxt;
      ch_q           <= ch_nxt;
      sample_CLK_out <= advance && (ch_nxt <= 6'd16);
      DAC_SYNC       <= !spi_active;
      DAC_SCLK       <= spi_active && st_nxt[0];
      DAC_DIN        <= spi_active && spi_src[bit_idx];
      if (spi_active && st_nxt == '0) spi_word_q <= out_q;
    end
  end

  assign main_state = {27'd0, st_q};
  assign channel    = ch_q;

  // ---------------- capture and configuration snapshot ----------------
  logic [5:0]  cap_slot;
  logic        capture, pend_q;
  logic [15:0] amp_q, reref_q, thr_q, start_q, stop_q, stop_max_q;
  logic [2:0]  gain_q;
  logic [6:0]  ns_q;
  logic        en_q, reref_sub_q, pol_q, fsm_mode_q, edge_fall_q;

  assign cap_slot = DAC_sequencer_en_1 ? DAC_sequencer_1[5:0] : '0;
  assign capture  = advance && (ch_q == cap_slot) && (st_q == '0);

  always_ff @(posedge dataclk) begin
    if (!reset) begin
      pend_q      <= 1'b0;
      amp_q       <= 16'h8000;
      reref_q     <= 16'h8000;
      thr_q       <= '0;
      start_q     <= '0;
      stop_q      <= '0;
      stop_max_q  <= '0;
      gain_q      <= '0;
      ns_q        <= '0;
      en_q        <= 1'b0;
      reref_sub_q <= 1'b0;
      pol_q       <= 1'b0;
      fsm_mode_q  <= 1'b0;
      edge_fall_q <= 1'b0;
    end else if (capture) begin
      pend_q      <= 1'b1;
      amp_q       <= ampl_to_DAC;
      reref_q     <= DAC_reref_register;
      thr_q       <= DAC_thrsh_1;
      start_q     <= DAC_start_win_1;
      stop_q      <= DAC_stop_win_1;
      stop_max_q  <= DAC_stop_max;
      gain_q      <= DAC_gain;
      ns_q        <= DAC_noise_suppress;
      en_q        <= DAC_en;
      reref_sub_q <= DAC_reref_mode && !DAC_1_input_is_ref;
      pol_q       <= DAC_thrsh_pol_1;
      fsm_mode_q  <= DAC_fsm_mode;
      edge_fall_q <= DAC_edge_type[0];
    end else if (pend_q && st_q == 5'd9) begin
      pend_q      <= 1'b0;
    end
  end

  // ---------------- conditioning datapath (one stage per main_state) ----------------
  logic signed [17:0] amp_s, ref_s, x_c, x_q;
  logic signed [18:0] d_q;
  logic signed [26:0] g_c;
  logic signed [15:0] y_c, y_q, z_q;
  logic        [16:0] mag_c;

  always_comb begin
    amp_s = $signed({2'b00, amp_q}) - 18'sd32768;
    ref_s = $signed({2'b00, reref_q}) - 18'sd32768;
    x_c   = reref_sub_q ? (amp_s - ref_s) : amp_s;
    g_c   = 27'(d_q) <<< gain_q;
    if (g_c > 27'sd32767)       y_c = 16'sh7FFF;
    else if (g_c < -27'sd32768) y_c = 16'sh8000;
    else                        y_c = g_c[15:0];
    mag_c = y_q[15] ? (17'd0 - 17'(y_q)) : 17'(y_q);
  end

`ifdef MAIN_REDUCED_HPF_EN
  logic        [15:0] coef_q;
  logic               hpf_en_q;
  logic signed [17:0] lp_q;
  logic signed [35:0] prod_q, prod_sh;
  logic               unused_cfg;

  assign prod_sh    = prod_q >>> 16;
  assign unused_cfg = ^{DAC_sequencer_1[15:6], DAC_edge_type[7:1]};

  always_ff @(posedge dataclk) begin
    if (!reset) begin
      coef_q   <= '0;
      hpf_en_q <= 1'b0;
      lp_q     <= '0;
      prod_q   <= '0;
    end else begin
      if (capture) begin
        coef_q   <= HPF_coefficient;
        hpf_en_q <= HPF_en;
      end
      if (pend_q && st_q == 5'd2 && !hpf_en_q) lp_q <= '0;
      if (pend_q && st_q == 5'd3) prod_q <= $signed({1'b0, coef_q}) * d_q;
      if (pend_q && st_q == 5'd4 && hpf_en_q) lp_q <= lp_q + $signed(prod_sh[17:0]);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{DAC_sequencer_1[15:6], DAC_edge_type[7:1], HPF_coefficient, HPF_en};
`endif

  always_ff @(posedge dataclk) begin
    if (!reset) begin
      x_q   <= '0;
      d_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      out_q <= 16'h8000;
    end else if (pend_q) begin
      case (st_q)
        5'd1: x_q <= x_c;
`ifdef MAIN_REDUCED_HPF_EN
        5'd2: d_q <= hpf_en_q ? (19'(x_q) - 19'(lp_q)) : 19'(x_q);
`else
        5'd2: d_q <= 19'(x_q);
`endif
        5'd5: y_q <= y_c;
        5'd6: z_q <= (!en_q || mag_c < {6'd0, ns_q, 4'd0}) ? 16'sd0 : y_q;
        5'd8: out_q <= {~z_q[15], z_q[14:0]};
        default: ;
      endcase
    end
  end

  assign DAC_output_register_1 = out_q;

  // ---------------- comparator and post-crossing window ----------------
  win_state_t  win_q, win_nxt;
  logic [15:0] cnt_q, cnt_nxt;
  logic        cmp_q, cmp_nxt, cmp_c, edge_hit, window_nxt, thresh_nxt, step9;

  assign step9 = pend_q && (st_q == 5'd9);

  always_comb begin
    win_nxt    = win_q;
    cnt_nxt    = cnt_q;
    cmp_nxt    = cmp_q;
    window_nxt = fsm_window_state;
    thresh_nxt = DAC_thresh_out;
    edge_hit   = 1'b0;
    cmp_c      = pol_q ? (out_q >= thr_q) : (out_q <= thr_q);
    if (step9) begin
      cmp_nxt  = cmp_c;
      edge_hit = edge_fall_q ? (!cmp_c && cmp_q) : (cmp_c && !cmp_q);
      case (win_q)
        WIN_IDLE:  if (edge_hit) begin
                     win_nxt = WIN_COUNT;
                     cnt_nxt = '0;
                   end
        WIN_COUNT: if (cnt_q == stop_max_q) win_nxt = WIN_IDLE;
                   else cnt_nxt = cnt_q + 16'd1;
        default:   win_nxt = WIN_IDLE;
      endcase
      window_nxt = (win_nxt == WIN_COUNT) && (start_q <= cnt_nxt) && (cnt_nxt <= stop_q);
      thresh_nxt = cmp_c && (!fsm_mode_q || window_nxt);
    end
  end

  always_ff @(posedge dataclk) begin
    if (!reset) begin
      win_q            <= WIN_IDLE;
      cnt_q            <= '0;
      cmp_q            <= 1'b0;
      fsm_window_state <= 1'b0;
      DAC_thresh_out   <= 1'b0;
    end else begin
      win_q            <= win_nxt;
      cnt_q            <= cnt_nxt;
      cmp_q            <= cmp_nxt;
      fsm_window_state <= window_nxt;
      DAC_thresh_out   <= thresh_nxt;
    end
  end

endmodule

// File: tb/tb_main_reduced_dac.sv
// Directed self-checking bench for main_reduced_dac; expected values are hand-derived.
module tb_main_reduced_dac;

  logic        dataclk = 1'b0;
  logic        reset;
  logic [15:0] ampl_to_DAC;
  logic        SPI_start;
  logic [15:0] DAC_sequencer_1;
  logic        DAC_sequencer_en_1;
  logic        DAC_en;
  logic [2:0]  DAC_gain;
  logic [6:0]  DAC_noise_suppress;
  logic [15:0] HPF_coefficient;
  logic        HPF_en;
  logic        DAC_reref_mode;
  logic        DAC_1_input_is_ref;
  logic [15:0] DAC_reref_register;
  logic [15:0] DAC_thrsh_1;
  logic        DAC_thrsh_pol_1;
  logic        DAC_fsm_mode;
  logic [7:0]  DAC_edge_type;
  logic [15:0] DAC_start_win_1, DAC_stop_win_1, DAC_stop_max;
  logic        DAC_thresh_out, fsm_window_state;
  logic [15:0] DAC_output_register_1;
  logic        DAC_SYNC, DAC_SCLK, DAC_DIN;
  logic [31:0] main_state;
  logic [5:0]  channel;
  logic        sample_CLK_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 dataclk = ~dataclk;

  main_reduced_dac dut (
    .dataclk(dataclk), .reset(reset), .ampl_to_DAC(ampl_to_DAC), .SPI_start(SPI_start),
    .DAC_sequencer_1(DAC_sequencer_1), .DAC_sequencer_en_1(DAC_sequencer_en_1),
    .DAC_en(DAC_en), .DAC_gain(DAC_gain), .DAC_noise_suppress(DAC_noise_suppress),
    .HPF_coefficient(HPF_coefficient), .HPF_en(HPF_en), .DAC_reref_mode(DAC_reref_mode),
    .DAC_1_input_is_ref(DAC_1_input_is_ref), .DAC_reref_register(DAC_reref_register),
    .DAC_thrsh_1(DAC_thrsh_1), .DAC_thrsh_pol_1(DAC_thrsh_pol_1), .DAC_fsm_mode(DAC_fsm_mode),
    .DAC_edge_type(DAC_edge_type), .DAC_start_win_1(DAC_start_win_1),
    .DAC_stop_win_1(DAC_stop_win_1), .DAC_stop_max(DAC_stop_max),
    .DAC_thresh_out(DAC_thresh_out), .fsm_window_state(fsm_window_state),
    .DAC_output_register_1(DAC_output_register_1), .DAC_SYNC(DAC_SYNC), .DAC_SCLK(DAC_SCLK),
    .DAC_DIN(DAC_DIN), .main_state(main_state), .channel(channel), .sample_CLK_out(sample_CLK_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns at the first negedge (current one included) where the sequencer sits at ch/st.
  task automatic wait_pos(input int ch, input int st);
    int n = 0;
    while (!(channel == ch && main_state == st) && n < 3000) begin
      @(negedge dataclk);
      n++;
    end
    if (!(channel == ch && main_state == st))
      check("wait_timeout", {channel, main_state[4:0]}, {6'(ch), 5'(st)});
  endtask

  // Lets one slot-0 capture take the current inputs; returns with all results settled.
  task automatic next_sample();
    wait_pos(0, 0);
    @(negedge dataclk);
    wait_pos(1, 0);
  endtask

  task automatic sample_check(input string tag, input logic [15:0] amp, input logic [15:0] exp);
    ampl_to_DAC = amp;
    next_sample();
    check(tag, DAC_output_register_1, exp);
  endtask

  task automatic win_check(input string tag, input logic [15:0] amp, input logic exp_win,
                           input logic exp_thr);
    ampl_to_DAC = amp;
    next_sample();
    check({tag, "_win"}, fsm_window_state, exp_win);
    check({tag, "_thr"}, DAC_thresh_out, exp_thr);
  endtask

  task automatic do_reset();
    @(negedge dataclk);
    reset = 1'b0;
    repeat (3) @(negedge dataclk);
    reset = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 3 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, seq_err, clk_err, high_cnt, last_rise, period, exp_ch;
    logic prev_clk, prev_sclk;
    logic [15:0] word;
    int rises, sync_low, diff, win_hits;

    reset = 1'b0; SPI_start = 1'b0; ampl_to_DAC = 16'h8000;
    DAC_sequencer_1 = '0; DAC_sequencer_en_1 = 1'b0; DAC_en = 1'b1; DAC_gain = '0;
    DAC_noise_suppress = '0; HPF_coefficient = '0; HPF_en = 1'b0; DAC_reref_mode = 1'b0;
    DAC_1_input_is_ref = 1'b0; DAC_reref_register = 16'h8000; DAC_thrsh_1 = 16'hFFFF;
    DAC_thrsh_pol_1 = 1'b1; DAC_fsm_mode = 1'b0; DAC_edge_type = '0;
    DAC_start_win_1 = '0; DAC_stop_win_1 = '0; DAC_stop_max = '0;

    repeat (4) @(negedge dataclk);
    check("rst_channel", channel, 0);
    check("rst_state", main_state, 0);
    check("rst_out", DAC_output_register_1, 16'h8000);
    check("rst_sync", DAC_SYNC, 1);
    check("rst_sclk", DAC_SCLK, 0);
    check("rst_din", DAC_DIN, 0);
    check("rst_thresh", DAC_thresh_out, 0);
    check("rst_window", fsm_window_state, 0);
    check("rst_sclk_out", sample_CLK_out, 0);

    // Sequencer: k-th edge after release puts the counters at (k/32 % 35, k % 32).
    reset = 1'b1; SPI_start = 1'b1;
    seq_err = 0; clk_err = 0; high_cnt = 0; last_rise = -1; period = 0; prev_clk = 1'b0;
    for (k = 1; k <= 2240; k++) begin
      @(negedge dataclk);
      exp_ch = (k / 32) % 35;
      if (main_state != 32'(k % 32) || channel != 6'(exp_ch)) seq_err++;
      if (sample_CLK_out != (exp_ch <= 16)) clk_err++;
      if (k >= 1120 && k < 2240 && sample_CLK_out) high_cnt++;
      if (sample_CLK_out && !prev_clk) begin
        if (last_rise > 1) period = k - last_rise;
        last_rise = k;
      end
      prev_clk = sample_CLK_out;
    end
    check("seq_counters", seq_err, 0);
    check("sample_clk_shape", clk_err, 0);
    check("sample_clk_high", high_cnt, 17 * 32);
    check("sample_clk_period", period, 1120);

    // Plain pass-through, then the same value on the serial bus in slot 34.
    sample_check("pass_9000", 16'h9000, 16'h9000);
    wait_pos(34, 0);
    word = '0; rises = 0; sync_low = 0; prev_sclk = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (!DAC_SYNC) sync_low++;
      if (DAC_SCLK && !prev_sclk) begin
        word = {word[14:0], DAC_DIN};
        rises++;
      end
      prev_sclk = DAC_SCLK;
      @(negedge dataclk);
    end
    check("spi_word", word, 16'h9000);
    check("spi_rises", rises, 16);
    check("spi_sync_low", sync_low, 32);
    check("spi_sync_idle", DAC_SYNC, 1);

    DAC_gain = 3'd2;
    sample_check("gain_8400", 16'h8400, 16'h9000);
    sample_check("gain_sat_pos", 16'hF000, 16'hFFFF);
    sample_check("gain_sat_neg", 16'h1000, 16'h0000);
    DAC_gain = 3'd0;

    DAC_noise_suppress = 7'd2;
    sample_check("ns_inside", 16'h8010, 16'h8000);
    sample_check("ns_outside", 16'h8030, 16'h8030);
    sample_check("ns_neg_inside", 16'h7FE1, 16'h8000);
    DAC_noise_suppress = 7'd0;

    DAC_en = 1'b0;
    sample_check("dac_disabled", 16'h9000, 16'h8000);
    DAC_en = 1'b1;

    DAC_reref_mode = 1'b1; DAC_reref_register = 16'h8100;
    sample_check("reref_sub", 16'h9000, 16'h8F00);
    DAC_1_input_is_ref = 1'b1;
    sample_check("reref_inhibit", 16'h9000, 16'h9000);
    DAC_reref_mode = 1'b0; DAC_1_input_is_ref = 1'b0;

    // Capture in slot 5: result appears at state 9; later input changes are ignored.
    DAC_sequencer_en_1 = 1'b1; DAC_sequencer_1 = 16'd5; ampl_to_DAC = 16'h8800;
    wait_pos(5, 1);
    ampl_to_DAC = 16'h9900;
    wait_pos(5, 8);
    check("slot5_before", DAC_output_register_1, 16'h9000);
    wait_pos(5, 9);
    check("slot5_after", DAC_output_register_1, 16'h8800);
    DAC_sequencer_en_1 = 1'b0; DAC_sequencer_1 = '0;

    // Window: rising crossing of 0x9000 held high; window spans cnt 0..3.
    DAC_thrsh_1 = 16'h9000; DAC_thrsh_pol_1 = 1'b1; DAC_fsm_mode = 1'b1;
    DAC_start_win_1 = 16'd0; DAC_stop_win_1 = 16'd3; DAC_stop_max = 16'd3;
    do_reset();
    win_check("w1", 16'h9100, 1, 1);
    win_check("w2", 16'h9100, 1, 1);
    win_check("w3", 16'h9100, 1, 1);
    win_check("w4", 16'h9100, 1, 1);
    win_check("w5", 16'h9100, 0, 0);
    win_check("w6", 16'h9100, 0, 0);

    DAC_stop_max = 16'd0; DAC_stop_win_1 = 16'd0;
    win_check("sm0_low", 16'h8000, 0, 0);
    win_check("sm0_hit", 16'h9100, 1, 1);
    win_check("sm0_end", 16'h9100, 0, 0);
    DAC_fsm_mode = 1'b0;
    win_check("mode0", 16'h9100, 0, 1);
    DAC_fsm_mode = 1'b1; DAC_edge_type = 8'd1; DAC_stop_max = 16'd3;
    win_check("fall_edge", 16'h8000, 1, 0);

    // start > stop never opens the window.
    DAC_edge_type = 8'd0; DAC_start_win_1 = 16'd2; DAC_stop_win_1 = 16'd1;
    do_reset();
    win_hits = 0;
    for (int i = 0; i < 3; i++) begin
      ampl_to_DAC = 16'h9100;
      next_sample();
      win_hits += int'(fsm_window_state) + int'(DAC_thresh_out);
    end
    check("start_gt_stop", win_hits, 0);
    DAC_fsm_mode = 1'b0; DAC_thrsh_pol_1 = 1'b0;
    win_check("pol0_below", 16'h8000, 0, 1);
    win_check("pol0_above", 16'h9100, 0, 0);

`ifdef MAIN_REDUCED_HPF_EN
    // lp after step: 30573*4096>>16 = 1910, so second output = 0x8000 + 4096 - 1910 = 0x888A.
    HPF_en = 1'b1; HPF_coefficient = 16'd30573;
    do_reset();
    sample_check("hpf_zero", 16'h8000, 16'h8000);
    sample_check("hpf_step1", 16'h9000, 16'h9000);
    sample_check("hpf_step2", 16'h9000, 16'h888A);
    for (int i = 0; i < 18; i++) begin
      ampl_to_DAC = 16'h9000;
      next_sample();
    end
    diff = int'(DAC_output_register_1) - 32768;
    check("hpf_settled", (diff >= -2 && diff <= 2), 1);
`else
    HPF_en = 1'b1; HPF_coefficient = 16'd30573;
    do_reset();
    sample_check("nohpf_step1", 16'h9000, 16'h9000);
    sample_check("nohpf_step2", 16'h9000, 16'h9000);
`endif
    HPF_en = 1'b0;

    // Reset in the middle of the serial word.
    wait_pos(34, 5);
    check("spi_busy", DAC_SYNC, 0);
    reset = 1'b0;
    @(negedge dataclk);
    check("abort_sync", DAC_SYNC, 1);
    check("abort_sclk", DAC_SCLK, 0);
    check("abort_channel", channel, 0);
    check("abort_out", DAC_output_register_1, 16'h8000);
    reset = 1'b1;

    // Dropping SPI_start finishes the frame and parks at 0/0.
    wait_pos(10, 0);
    SPI_start = 1'b0;
    @(negedge dataclk);
    check("stop_continues", main_state, 1);
    wait_pos(0, 0);
    repeat (50) @(negedge dataclk);
    check("stop_channel", channel, 0);
    check("stop_state", main_state, 0);
    check("stop_sync", DAC_SYNC, 1);
    check("stop_sample_clk", sample_CLK_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
